// File: rtl/bcd_step_pkg.sv
// Shared types and the single-digit BCD step helper for bcd_step_register.
package bcd_step_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STEP   = 2'd1,
        S_CARRY  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         BCD_W   = 4;

    // Adds or subtracts k (0..9) on one BCD digit; returns {carry_or_borrow, digit}.
    // A non-BCD input digit is read as 9 going up and as 0 going down, so the
    // result is always a valid BCD digit.
    function automatic logic [4:0] bcd_digit_step(input logic [3:0] d,
                                                  input logic [3:0] k,
                                                  input logic       up);
        logic [3:0] dd;
        logic [4:0] sum;
        logic [4:0] res;
        if (up) begin
            dd  = (d > BCD_MAX) ? BCD_MAX : d;
            sum = {1'b0, dd} + {1'b0, k};
            if (sum > 5'd9) begin
                res = {1'b1, 4'(sum - 5'd10)};
            end else begin
                res = {1'b0, sum[3:0]};
            end
        end else begin
            dd = (d > BCD_MAX) ? 4'd0 : d;
            if (dd >= k) begin
                res = {1'b0, dd - k};
            end else begin
                // dd < k <= 9, so dd + 10 - k lands in 1..9 even with 4-bit wrap
                res = {1'b1, dd + 4'd10 - k};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_step_digit.sv
// Combinational +/-k on a single BCD digit with carry/borrow out.
module bcd_step_digit
    import bcd_step_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic [3:0] i_k,
    input  logic       i_up,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_res;

    assign w_res   = bcd_digit_step(i_digit, i_k, i_up);
    assign o_digit = w_res[3:0];
    assign o_carry = w_res[4];

endmodule

// File: rtl/bcd_step_register.sv
// Multi-digit BCD accumulator: applies +/-STEP to digit 0, ripples the carry
// one digit per cycle, then commits the whole value at once.
// Build option: define BCD_STEP_SATURATE_EN to reject wrapping operations
// (value held, overflow/underflow still pulses) instead of wrapping modulo 10^NDIGITS.
module bcd_step_register
    import bcd_step_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int STEP    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   add,
    input  logic                   sub,
    output logic                   ready,
    output logic [4*NDIGITS-1:0]   digits,
    output logic [4*NDIGITS-1:0]   digits_n,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int             IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
    localparam logic [3:0]     STEP_K   = 4'(STEP);

    state_t           r_state;
    logic [3:0]       r_digits [NDIGITS];
    logic [3:0]       r_work   [NDIGITS];
    logic             r_dir;
    logic             r_wrap;
    logic             r_ready;
    logic             r_overflow;
    logic             r_underflow;
    logic [IDX_W-1:0] r_idx;

    logic [3:0]             w_k;
    logic [3:0]             w_cur;
    logic [3:0]             w_new;
    logic                   w_carry;
    logic [4*NDIGITS-1:0]   w_digits_flat;
    logic                   w_show;

    // One digit adder serves both paths: k=STEP on digit 0, k=1 while rippling.
    assign w_k   = (r_state == S_STEP) ? STEP_K : 4'd1;
    assign w_cur = r_work[r_idx];

    bcd_step_digit u_digit (
        .i_digit (w_cur),
        .i_k     (w_k),
        .i_up    (r_dir),
        .o_digit (w_new),
        .o_carry (w_carry)
    );

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_flat
            assign w_digits_flat[gi*BCD_W +: BCD_W] = r_digits[gi];
        end
    endgenerate

    // Inverse is blanked only when idle at zero.
    assign w_show    = (r_state != S_IDLE) || (|w_digits_flat);
    assign digits    = w_digits_flat;
    assign digits_n  = w_show ? ~w_digits_flat : '0;
    assign ready     = r_ready;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Step/ripple/commit controller; committed digits change only in COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_wrap      <= 1'b0;
            r_ready     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_idx       <= '0;
            for (int i = 0; i < NDIGITS; i++) begin
                r_digits[i] <= 4'd0;
                r_work[i]   <= 4'd0;
            end
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (add ^ sub) begin
                        r_dir   <= add;
                        r_wrap  <= 1'b0;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        for (int i = 0; i < NDIGITS; i++) begin
                            r_work[i] <= r_digits[i];
                        end
                        r_state <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_work[0] <= w_new;
                    if (!w_carry) begin
                        r_state <= S_COMMIT;
                    end else if (NDIGITS == 1) begin
                        r_wrap  <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx   <= IDX_W'(1);
                        r_state <= S_CARRY;
                    end
                end
                S_CARRY: begin
                    r_work[r_idx] <= w_new;
                    if (!w_carry) begin
                        r_state <= S_COMMIT;
                    end else if (r_idx == LAST_IDX) begin
                        r_wrap  <= 1'b1;
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_COMMIT: begin
`ifdef BCD_STEP_SATURATE_EN
                    if (!r_wrap) begin
                        for (int i = 0; i < NDIGITS; i++) begin
                            r_digits[i] <= r_work[i];
                        end
                    end
`else
                    for (int i = 0; i < NDIGITS; i++) begin
                        r_digits[i] <= r_work[i];
                    end
`endif
                    r_overflow  <= r_wrap & r_dir;
                    r_underflow <= r_wrap & ~r_dir;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_step_register.sv
// Scoreboard bench for bcd_step_register: the driver pushes expected results
// from an integer-arithmetic model, a monitor pops them when ready returns.
module tb_bcd_step_register;

    localparam int NDIGITS = 4;
    localparam int STEP    = 2;
    localparam int W       = 4 * NDIGITS;
    localparam int MOD     = 10 ** NDIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         add;
    logic         sub;
    logic         ready;
    logic [W-1:0] digits;
    logic [W-1:0] digits_n;
    logic         overflow;
    logic         underflow;

    bcd_step_register #(.NDIGITS(NDIGITS), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .add       (add),
        .sub       (sub),
        .ready     (ready),
        .digits    (digits),
        .digits_n  (digits_n),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   val;
        logic ovf;
        logic unf;
        int   lat;
        logic up;
    } exp_t;

    exp_t sb_q[$];
    int   m_val    = 0;
    int   checks   = 0;
    int   fails    = 0;
    bit   mon_sync = 1'b0;
    int   txn      = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input int v, input int i);
        int t;
        t = v;
        for (int j = 0; j < i; j++) t = t / 10;
        return t % 10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decimal model: value +/- STEP modulo 10^NDIGITS; busy time is 2 cycles
    // plus one per higher digit the carry reaches.
    task automatic push_req(input logic up);
        exp_t e;
        int   nv;
        bit   wrap;
        int   n;
        nv   = up ? m_val + STEP : m_val - STEP;
        wrap = 1'b0;
        if (nv >= MOD) begin nv = nv - MOD; wrap = 1'b1; end
        if (nv < 0)    begin nv = nv + MOD; wrap = 1'b1; end
        n = 0;
        if (up ? (digit_of(m_val, 0) + STEP > 9) : (digit_of(m_val, 0) < STEP)) begin
            for (int i = 1; i < NDIGITS; i++) begin
                n++;
                if (digit_of(m_val, i) != (up ? 9 : 0)) break;
            end
        end
`ifdef BCD_STEP_SATURATE_EN
        if (wrap) nv = m_val;
`endif
        e.val = nv;
        e.ovf = wrap && up;
        e.unf = wrap && !up;
        e.lat = 2 + n;
        e.up  = up;
        sb_q.push_back(e);
        m_val = nv;
    endtask

    // Drive one cycle of inputs just after a rising edge; a request seen with
    // ready high is taken at the next edge.
    task automatic cyc(input logic a, input logic s);
        @(posedge clk);
        #1;
        add = a;
        sub = s;
        if (ready === 1'b1 && (a ^ s)) push_req(a);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        cyc(1'b0, 1'b0);
        while (ready !== 1'b1 && g < 64) begin
            cyc(1'b0, 1'b0);
            g++;
        end
        if (g >= 64) begin
            checks++;
            fails++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 64 cycles", ready);
        end
    endtask

    task automatic op(input logic a, input logic s);
        wait_idle();
        cyc(a, s);
    endtask

    task automatic walk_to(input int target);
        int g;
        g = 0;
        while (m_val != target && g < 6000) begin
            op(1'b1, 1'b0);
            g++;
        end
        wait_idle();
        chk("walk_digits", 32'(digits), 32'(to_bcd(target)));
    endtask

    // Monitor: checks every idle/busy cycle and retires one transaction per ready rise.
    logic         prev_ready;
    int           busy;
    int           exp_cur;
    exp_t         it;
    logic [W-1:0] exp_bits;
    logic [W-1:0] exp_n;

    initial begin
        prev_ready = 1'b1;
        busy       = 0;
        exp_cur    = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (mon_sync) begin
                mon_sync   = 1'b0;
                prev_ready = 1'b1;
                busy       = 0;
                exp_cur    = 0;
            end
            exp_bits = to_bcd(exp_cur);
            if (ready !== 1'b1) begin
                busy++;
                chk("busy_digits_stable", 32'(digits), 32'(exp_bits));
                chk("busy_overflow", 32'(overflow), 32'd0);
                chk("busy_underflow", 32'(underflow), 32'd0);
                exp_n = ~exp_bits;
                chk("busy_digits_n", 32'(digits_n), 32'(exp_n));
            end else begin
                if (!prev_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_commit: got digits=%h expected no transaction", digits);
                    end else begin
                        it       = sb_q.pop_front();
                        exp_cur  = it.val;
                        exp_bits = to_bcd(exp_cur);
                        txn++;
                        $display("txn %0d: %s -> digits=%h ovf=%b unf=%b busy=%0d (exp %h %b %b %0d)",
                                 txn, it.up ? "add" : "sub", digits, overflow, underflow, busy,
                                 exp_bits, it.ovf, it.unf, it.lat);
                        chk("commit_digits", 32'(digits), 32'(exp_bits));
                        chk("commit_overflow", 32'(overflow), 32'(it.ovf));
                        chk("commit_underflow", 32'(underflow), 32'(it.unf));
                        chk("commit_latency", 32'(busy), 32'(it.lat));
                    end
                end else begin
                    chk("idle_digits", 32'(digits), 32'(exp_bits));
                    chk("idle_overflow", 32'(overflow), 32'd0);
                    chk("idle_underflow", 32'(underflow), 32'd0);
                end
                busy  = 0;
                exp_n = (exp_cur != 0) ? ~exp_bits : '0;
                chk("idle_digits_n", 32'(digits_n), 32'(exp_n));
            end
            prev_ready = ready;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        add = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mon_sync = 1'b1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_digits", 32'(digits), 32'd0);
        chk("reset_digits_n", 32'(digits_n), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);

        // first step from zero, then climb to 0098 and ripple into the hundreds
        op(1'b1, 1'b0);
        walk_to(98);
        op(1'b1, 1'b0);

        // simultaneous add/sub is ignored; requests during busy are dropped
        op(1'b1, 1'b1);
        op(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        // reset while the carry is rippling
        walk_to(998);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        add = 1'b0;
        sb_q.delete();
        m_val    = 0;
        mon_sync = 1'b1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_digits", 32'(digits), 32'd0);
        chk("abort_overflow", 32'(overflow), 32'd0);

        // wrap below zero, then wrap above the maximum
        op(1'b0, 1'b1);
        walk_to(MOD - STEP);
        op(1'b1, 1'b0);

        // random traffic including both-high, idle and busy-time requests
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 9);
            cyc(r < 4, (r >= 3) && (r < 7));
        end

        repeat (30) cyc(1'b0, 1'b0);
        chk("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
